// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Selects the data bits that belong to a frame of the given word length.
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 8'h1f;
      WLS_6:   return 8'h3f;
      WLS_7:   return 8'h7f;
      default: return 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/uart_transmitter_bit_timer.sv
// Bit-period tick counter for the UART transmitter: counts TXCLK enables and
// flags the last tick of a full or half bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic CLK,
  input  logic RST,
  input  logic TXCLK,
  input  logic clear,
  input  logic half,
  output logic done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TC_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] TC_HALF = CW'(OVERSAMPLE / 2 - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] tc;

  assign tc   = half ? TC_HALF : TC_FULL;
  assign done = TXCLK && (count == tc);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (TXCLK) begin
      count <= (count == tc) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART serial transmit engine: pops one FIFO byte per frame and shifts it out
// on SOUT. Parity generation is built only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for TXSTART
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP1  | first stop bit
// STOP2  | second stop bit, half length for 5-bit words
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXCLK,
  input  logic       TXSTART,
  input  logic       CLEAR,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] DIN,
  output logic       READ,
  output logic       TXFINISHED,
  output logic       SOUT
);

  uart_tx_state_t state;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  logic [2:0]     last_idx;
  logic [1:0]     wls_q;
  logic           stb_q;
  logic           line_cur;
  logic           bit_done;
  logic           timer_clear;
  logic           timer_half;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic din_xor;

  assign din_xor = ^(DIN & wls_mask(WLS));
`else
  logic unused_lcr;

  assign unused_lcr = ^{PEN, EPS, SP};
`endif

  assign last_idx    = 3'd4 + {1'b0, wls_q};
  assign timer_clear = CLEAR || (state == IDLE);
  assign timer_half  = (state == STOP2) && (wls_q == WLS_5);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .CLK  (CLK),
    .RST  (RST),
    .TXCLK(TXCLK),
    .clear(timer_clear),
    .half (timer_half),
    .done (bit_done)
  );

  // Line level the FSM is holding; SOUT re-registers it so BC can override.
  always_comb begin
    line_cur = 1'b1;
    case (state)
      START:   line_cur = 1'b0;
      DATA:    line_cur = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_cur = par_bit_q;
`endif
      default: line_cur = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      SOUT       <= 1'b1;
      READ       <= 1'b0;
      TXFINISHED <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      wls_q      <= WLS_5;
      stb_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      READ       <= 1'b0;
      TXFINISHED <= 1'b0;
      SOUT       <= BC ? 1'b0 : line_cur;
      if (CLEAR) begin
        state <= IDLE;
        SOUT  <= ~BC;
      end else begin
        case (state)
          IDLE: begin
            if (TXSTART) begin
              shift     <= DIN;
              wls_q     <= WLS;
              stb_q     <= STB;
              bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              par_en_q  <= PEN;
              par_bit_q <= SP ? ~EPS : (EPS ? din_xor : ~din_xor);
`endif
              state     <= START;
              READ      <= 1'b1;
              SOUT      <= 1'b0;
            end
          end
          START: begin
            if (bit_done) begin
              state <= DATA;
              SOUT  <= ~BC & shift[0];
            end
          end
          DATA: begin
            if (bit_done) begin
              if (bit_idx == last_idx) begin
`ifdef UART_TX_PARITY_EN
                if (par_en_q) begin
                  state <= PARITY;
                  SOUT  <= ~BC & par_bit_q;
                end else begin
                  state <= STOP1;
                  SOUT  <= ~BC;
                end
`else
                state <= STOP1;
                SOUT  <= ~BC;
`endif
              end else begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
                SOUT    <= ~BC & shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_done) begin
              state <= STOP1;
              SOUT  <= ~BC;
            end
          end
`endif
          STOP1: begin
            if (bit_done) begin
              if (stb_q) begin
                state <= STOP2;
              end else begin
                state      <= IDLE;
                TXFINISHED <= 1'b1;
              end
            end
          end
          STOP2: begin
            if (bit_done) begin
              state      <= IDLE;
              TXFINISHED <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
